// File: rtl/vending_def.sv
// rtl/vending_def.sv - shared coin/item tables and FSM state encoding for vending_controller
package vending_def;
    localparam int kNumCoins = 3;
    localparam int kNumItems = 4;

    localparam logic [31:0] kCoin100  = 32'd100;
    localparam logic [31:0] kCoin500  = 32'd500;
    localparam logic [31:0] kCoin1000 = 32'd1000;

    localparam logic [31:0] kPrice0 = 32'd400;
    localparam logic [31:0] kPrice1 = 32'd500;
    localparam logic [31:0] kPrice2 = 32'd1000;
    localparam logic [31:0] kPrice3 = 32'd2000;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StCredit = 2'd1;
    localparam logic [1:0] StReturn = 2'd2;

    // Anything other than exactly one coin bit is worth nothing, which rejects multi-hot inserts.
    function automatic logic [31:0] coin_value(input logic [kNumCoins-1:0] coin);
        case (coin)
            3'b001:  coin_value = kCoin100;
            3'b010:  coin_value = kCoin500;
            3'b100:  coin_value = kCoin1000;
            default: coin_value = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] item_price(input int idx);
        case (idx)
            0:       item_price = kPrice0;
            1:       item_price = kPrice1;
            2:       item_price = kPrice2;
            3:       item_price = kPrice3;
            default: item_price = 32'd0;
        endcase
    endfunction
endpackage

// File: rtl/vend_wait_timer.sv
// rtl/vend_wait_timer.sv - inactivity countdown; zero_o flags that the count is zero after this edge
module vend_wait_timer #(
    parameter int WAIT_TIME = 100
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);
    localparam int CntW = $clog2(WAIT_TIME + 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CntW'(WAIT_TIME);
        end else if (en_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    assign zero_o = (count_d == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - coin/credit/dispense/change FSM; VEND_STOCK_COUNT_EN adds per-item stock counters
module vending_controller
    import vending_def::*;
#(
    parameter int WAIT_TIME   = 100,
    parameter int MAX_BALANCE = 5000
`ifdef VEND_STOCK_COUNT_EN
    ,
    parameter int STOCK_INIT  = 3
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [kNumCoins-1:0] i_input_coin,
    input  logic [kNumItems-1:0] i_select_item,
    input  logic                 i_trigger_return,
    output logic [kNumItems-1:0] o_available_item,
    output logic [kNumItems-1:0] o_output_item,
    output logic [kNumCoins-1:0] o_return_coin,
    output logic [31:0]          o_balance,
    output logic                 o_busy
);
    logic [1:0]           state_q, state_d;
    logic [31:0]          balance_q, balance_d;
    logic [kNumItems-1:0] item_q, item_d;
    logic [kNumCoins-1:0] coin_q, coin_d;
    logic [kNumItems-1:0] stock_ok, avail, sel_onehot;
    logic [31:0]          coin_val, sel_price;
    logic                 accepting, coin_fits, coin_accept, coin_reject, dispense;
    logic                 timer_load, timer_en, timer_zero;

    assign accepting   = (state_q != StReturn);
    assign coin_val    = coin_value(i_input_coin);
    assign coin_fits   = (balance_q + coin_val) <= 32'(MAX_BALANCE);
    assign coin_accept = accepting && (coin_val != '0) && coin_fits;
    assign coin_reject = accepting && (coin_val != '0) && !coin_fits;

    // Descending scan so the lowest-index requested item wins.
    always_comb begin
        sel_onehot = '0;
        sel_price  = '0;
        for (int i = kNumItems - 1; i >= 0; i--) begin
            if (i_select_item[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_price     = item_price(i);
            end
        end
    end

    always_comb begin
        avail = '0;
        for (int i = 0; i < kNumItems; i++) begin
            avail[i] = (item_price(i) <= balance_q) && stock_ok[i];
        end
    end

    assign dispense   = accepting && |(sel_onehot & avail);
    assign timer_load = coin_accept || dispense;
    assign timer_en   = (state_q == StCredit);

    vend_wait_timer #(.WAIT_TIME(WAIT_TIME)) u_wait_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (timer_load),
        .en_i    (timer_en),
        .zero_o  (timer_zero)
    );

    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        item_d    = '0;
        coin_d    = '0;
        case (state_q)
            StIdle, StCredit: begin
                if (coin_accept) balance_d = balance_d + coin_val;
                if (coin_reject) coin_d = i_input_coin;
                if (dispense) begin
                    item_d    = sel_onehot;
                    balance_d = balance_d - sel_price;
                end
                if (balance_d == '0) begin
                    state_d = StIdle;
                end else if (state_q == StCredit && (i_trigger_return || timer_zero)) begin
                    state_d = StReturn;
                end else begin
                    state_d = StCredit;
                end
            end
            StReturn: begin
                // The edge that pays out the last coin also leaves RETURN.
                if (balance_q >= kCoin1000)     coin_d = 3'b100;
                else if (balance_q >= kCoin500) coin_d = 3'b010;
                else if (balance_q >= kCoin100) coin_d = 3'b001;
                balance_d = balance_q - coin_value(coin_d);
                if (balance_d == '0 || coin_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef VEND_STOCK_COUNT_EN
    logic [7:0] stock_q [kNumItems];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < kNumItems; i++) stock_q[i] <= 8'(STOCK_INIT);
        end else begin
            for (int i = 0; i < kNumItems; i++) begin
                if (item_d[i]) stock_q[i] <= stock_q[i] - 8'd1;
            end
        end
    end

    always_comb begin
        stock_ok = '0;
        for (int i = 0; i < kNumItems; i++) stock_ok[i] = (stock_q[i] != 8'd0);
    end
`else
    assign stock_ok = '1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            balance_q <= '0;
            item_q    <= '0;
            coin_q    <= '0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            item_q    <= item_d;
            coin_q    <= coin_d;
        end
    end

    assign o_available_item = (state_q == StReturn) ? '0 : avail;
    assign o_output_item    = item_q;
    assign o_return_coin    = coin_q;
    assign o_balance        = balance_q;
    assign o_busy           = (state_q == StReturn);
endmodule
